// File: rtl/tim_input_capture_if.sv
// ============================================================================
// Module     : tim_input_capture_if
// Description: Control/status bundle between the timer core and one
//              input-capture channel.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tim_input_capture_if #(
  parameter int CNT_W = 16
);
  logic             en;
  logic             tick;
  logic             cap_in;
  logic [1:0]       edge_sel;
  logic [3:0]       filt;
  logic             cap_ack;
  logic [CNT_W-1:0] cap_val;
  logic             cap_valid;
  logic             cap_sat;
  logic             ovr;
  logic             irq;

  modport master (
    output en, tick, cap_in, edge_sel, filt, cap_ack,
    input  cap_val, cap_valid, cap_sat, ovr, irq
  );

  modport slave (
    input  en, tick, cap_in, edge_sel, filt, cap_ack,
    output cap_val, cap_valid, cap_sat, ovr, irq
  );
endinterface

`default_nettype wire

// File: rtl/tim_input_capture.sv
// ============================================================================
// Module     : tim_input_capture
// Description: Timer input-capture channel; measures the interval between
//              qualified, glitch-filtered pin edges in prescaled ticks.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module tim_input_capture #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  wire logic             clk,
  input  wire logic             rst,
  tim_input_capture_if.slave    bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sync;
  logic                   sync_out;
  logic                   level;
  logic                   level_q;
  logic [3:0]             fcnt;
  logic                   rise;
  logic                   fall;
  logic                   evt_match;
  logic                   evt;

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_inc;
  logic [CNT_W-1:0]       cap_val_q;
  logic                   cap_valid_q;
  logic                   cap_sat_q;
  logic                   ovr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], bus.cap_in};
    end
  end

  assign sync_out = sync[SYNC_STAGES-1];

  // The filtered level only moves after filt+1 consecutive disagreeing
  // samples; any agreeing sample restarts the run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level   <= 1'b0;
      level_q <= 1'b0;
      fcnt    <= 4'd0;
    end else begin
      level_q <= level;
      if (sync_out == level) begin
        fcnt <= 4'd0;
      end else if (fcnt >= bus.filt) begin
        level <= sync_out;
        fcnt  <= 4'd0;
      end else begin
        fcnt <= fcnt + 4'd1;
      end
    end
  end

  always_comb begin
    rise      = level & ~level_q;
    fall      = ~level & level_q;
    evt_match = 1'b0;
    unique case (bus.edge_sel)
      2'b00:   evt_match = rise;
      2'b01:   evt_match = fall;
      2'b10:   evt_match = rise | fall;
      default: evt_match = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt <= 1'b0;
    end else begin
      evt <= evt_match;
    end
  end

  // Saturating count including a tick that lands on the capture clock.
  assign cnt_inc = (bus.tick && (cnt != CNT_MAX)) ? cnt + CNT_W'(1) : cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      cap_val_q   <= '0;
      cap_valid_q <= 1'b0;
      cap_sat_q   <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      if (bus.cap_ack) begin
        cap_valid_q <= 1'b0;
        ovr_q       <= 1'b0;
      end

      if (!bus.en) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            cnt   <= '0;
            state <= ARM;
          end
          ARM: begin
            cnt <= '0;
            if (evt) begin
              state <= MEAS;
            end
          end
          MEAS: begin
            if (evt) begin
              // Later assignments override the ack clear: capture wins.
              cap_val_q   <= cnt_inc;
              cap_sat_q   <= (cnt_inc == CNT_MAX);
              cap_valid_q <= 1'b1;
              cnt         <= '0;
              if (cap_valid_q && !bus.cap_ack) begin
                ovr_q <= 1'b1;
              end
            end else begin
              cnt <= cnt_inc;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.cap_val   = cap_val_q;
  assign bus.cap_valid = cap_valid_q;
  assign bus.cap_sat   = cap_sat_q;
  assign bus.ovr       = ovr_q;
  assign bus.irq       = cap_valid_q | ovr_q;

endmodule

`default_nettype wire

// File: tb/tb_tim_input_capture.sv
// ============================================================================
// Module     : tb_tim_input_capture
// Description: Scoreboard bench for the input-capture channel.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tim_input_capture;

  localparam int CNT_W = 8;
  localparam int SYNC  = 2;
  localparam int MAXV  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;

  tim_input_capture_if #(.CNT_W(CNT_W)) ifc ();

  tim_input_capture #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  typedef struct {
    int val;
    bit sat;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   div   = 1;
  int   tcnt  = 0;
  int   mode  = 0;
  int   cur_filt = 0;
  bit   armed = 0;
  int   last_q = 0;
  int   last_gap = 0;
  bit   pin_now = 0;
  bit   mon_en = 1;
  bit   auto_ack = 1;
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc = cyc + 1;

  // Free-running timebase: one pulse every div clocks.
  always @(negedge clk) begin
    ifc.tick = ((tcnt % div) == 0);
    tcnt = tcnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: each new capture pops the oldest expected interval.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && ifc.cap_valid === 1'b1 && prev_valid !== 1'b1) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_capture: got cap_val=%0d, expected no capture (cycle %0d)",
                 ifc.cap_val, cyc);
      end else begin
        e = q.pop_front();
        check("cap_val", ifc.cap_val, e.val);
        check("cap_sat", ifc.cap_sat, e.sat);
      end
    end
    if (auto_ack) ifc.cap_ack = ifc.cap_valid;
    prev_valid = ifc.cap_valid;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_interval(input int clks);
    exp_t e;
    int   n;
    n = clks / div;
    if (n > MAXV) n = MAXV;
    e.val = n;
    e.sat = (n == MAXV);
    q.push_back(e);
  endtask

  // Drive the pin and update the reference model of qualified edges.
  task automatic set_pin(input bit v);
    bit qual;
    if (v == pin_now) return;
    qual = (mode == 0 && v) || (mode == 1 && !v) || (mode == 2);
    ifc.cap_in = v;
    pin_now    = v;
    if (qual) begin
      last_gap = cyc - last_q;
      if (armed && mon_en) push_interval(last_gap);
      armed  = 1;
      last_q = cyc;
    end
  endtask

  task automatic seg(input bit v, input int clks);
    set_pin(v);
    step(clks);
  endtask

  task automatic configure(input int m, input int d, input int f);
    ifc.en = 1'b0;
    step(3);
    mode         = m;
    ifc.edge_sel = 2'(m);
    div          = d;
    cur_filt     = f;
    ifc.filt     = 4'(f);
    step(4);
    ifc.en = 1'b1;
    step(3);
    armed = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int dvals[3];
    int nseg;
    dvals[0] = 1; dvals[1] = 2; dvals[2] = 4;

    rst          = 1'b1;
    ifc.en       = 1'b0;
    ifc.tick     = 1'b0;
    ifc.cap_in   = 1'b0;
    ifc.edge_sel = 2'b00;
    ifc.filt     = 4'd0;
    ifc.cap_ack  = 1'b0;
    step(4);
    check("rst_cap_val",   ifc.cap_val,   0);
    check("rst_cap_valid", ifc.cap_valid, 0);
    check("rst_cap_sat",   ifc.cap_sat,   0);
    check("rst_ovr",       ifc.ovr,       0);
    check("rst_irq",       ifc.irq,       0);
    rst = 1'b0;
    step(3);

    // Rising edges 100 clks apart, tick every clk.
    configure(0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      seg(1, 50);
      seg(0, 50);
    end
    step(10);

    // Tick every 4th clk, period 400 clks; final capture acknowledged by hand.
    configure(0, 4, 0);
    seg(1, 200); seg(0, 200);
    seg(1, 200); seg(0, 200);
    auto_ack = 0;
    seg(1, 20);
    check("t2_valid_before_ack", ifc.cap_valid, 1);
    check("t2_irq_before_ack",   ifc.irq,       1);
    ifc.cap_ack = 1'b1;
    step(1);
    ifc.cap_ack = 1'b0;
    check("t2_valid_after_ack", ifc.cap_valid, 0);
    check("t2_irq_after_ack",   ifc.irq,       0);
    auto_ack = 1;
    seg(0, 30);

    // Glitch filter with filt=3.
    configure(0, 1, 3);
    seg(1, 20); seg(0, 40);
    ifc.cap_in = 1'b1;
    step(2);
    ifc.cap_in = 1'b0;
    step(20);
    check("t3_glitch_no_capture", ifc.cap_valid, 0);
    set_pin(1);
    step(6);
    set_pin(0);
    step(SYNC + 3 + 2 - 6);
    check("t3_not_yet_captured", ifc.cap_valid, 0);
    step(1);
    check("t3_capture_latency", ifc.cap_valid, 1);
    step(30);

    // Overcapture and ack/capture collision, checked directly.
    mon_en   = 0;
    auto_ack = 0;
    configure(0, 1, 0);
    seg(1, 10); seg(0, 30);
    seg(1, 10); seg(0, 50);
    seg(1, 10); seg(0, 40);
    seg(1, 10);
    check("t4_ovr",       ifc.ovr,       1);
    check("t4_irq",       ifc.irq,       1);
    check("t4_cap_valid", ifc.cap_valid, 1);
    check("t4_cap_val",   ifc.cap_val,   last_gap);
    ifc.cap_ack = 1'b1;
    step(1);
    ifc.cap_ack = 1'b0;
    check("t4_ovr_cleared",   ifc.ovr,       0);
    check("t4_valid_cleared", ifc.cap_valid, 0);
    seg(0, 25);
    seg(1, 10);
    check("t4_valid_again", ifc.cap_valid, 1);
    check("t4_no_ovr",      ifc.ovr,       0);
    seg(0, 20);
    set_pin(1);
    step(SYNC + 0 + 2);
    ifc.cap_ack = 1'b1;
    step(1);
    ifc.cap_ack = 1'b0;
    check("t4_collide_valid", ifc.cap_valid, 1);
    check("t4_collide_ovr",   ifc.ovr,       0);
    check("t4_collide_val",   ifc.cap_val,   last_gap);
    step(10);
    ifc.cap_ack = 1'b1;
    step(1);
    ifc.cap_ack = 1'b0;
    seg(0, 20);
    prev_valid = ifc.cap_valid;
    mon_en   = 1;
    auto_ack = 1;

    // Saturation at CNT_W=8 and the exact-boundary periods.
    configure(0, 1, 0);
    seg(1, 150); seg(0, 150);
    seg(1, 150); seg(0, 150);
    seg(1, 25);  seg(0, 25);
    seg(1, 128); seg(0, 127);
    seg(1, 127); seg(0, 127);
    seg(1, 20);  seg(0, 20);

    // Reserved edge_sel: edges ignored while the count keeps running.
    configure(0, 1, 0);
    seg(1, 10); seg(0, 10);
    mode = 3;
    ifc.edge_sel = 2'b11;
    for (int i = 0; i < 3; i++) begin
      seg(1, 10);
      seg(0, 10);
    end
    check("reserved_no_capture", ifc.cap_valid, 0);
    mode = 0;
    ifc.edge_sel = 2'b00;
    seg(1, 20); seg(0, 20);

    // Both edges, 30/70 duty, then reset in the middle of a high phase.
    configure(2, 1, 0);
    for (int i = 0; i < 3; i++) begin
      seg(1, 30);
      seg(0, 70);
    end
    set_pin(1);
    step(15);
    rst = 1'b1;
    #1;
    check("t6_rst_cap_val",   ifc.cap_val,   0);
    check("t6_rst_cap_valid", ifc.cap_valid, 0);
    check("t6_rst_cap_sat",   ifc.cap_sat,   0);
    check("t6_rst_ovr",       ifc.ovr,       0);
    check("t6_rst_irq",       ifc.irq,       0);
    ifc.cap_in = 1'b0;
    pin_now    = 0;
    step(5);
    rst   = 1'b0;
    armed = 0;
    step(5);
    seg(1, 30); seg(0, 70);
    seg(1, 30); seg(0, 40);

    // Randomized blocks: mode, prescale and filter drawn per block.
    for (int b = 0; b < 6; b++) begin
      configure($urandom_range(0, 2), dvals[$urandom_range(0, 2)], $urandom_range(0, 7));
      nseg = 2 * $urandom_range(3, 5);
      for (int s = 0; s < nseg; s++) begin
        seg(((s % 2) == 0), $urandom_range(12, 40) * div);
      end
      step(40);
    end

    check("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
